// File: rtl/mdu_pkg.sv
// Shared constants and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    // funct3 encodings of the M-extension operations
    localparam logic [2:0] MduMul    = 3'd0;
    localparam logic [2:0] MduMulh   = 3'd1;
    localparam logic [2:0] MduMulhsu = 3'd2;
    localparam logic [2:0] MduMulhu  = 3'd3;
    localparam logic [2:0] MduDiv    = 3'd4;
    localparam logic [2:0] MduDivu   = 3'd5;
    localparam logic [2:0] MduRem    = 3'd6;
    localparam logic [2:0] MduRemu   = 3'd7;

    // Position of the W-variant flag inside the 4-bit op field
    localparam int MduWord = 3;

    // Operand width used by the W-variant operations
    localparam int WordBits = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mdu_state_e;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic src1Signed(input logic [2:0] f3);
        return (f3 == MduMulh) || (f3 == MduMulhsu) || (f3 == MduDiv) || (f3 == MduRem);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM
    function automatic logic src2Signed(input logic [2:0] f3);
        return (f3 == MduMulh) || (f3 == MduDiv) || (f3 == MduRem);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath shared by shift-add multiply and restoring divide.
// Works on unsigned magnitudes; the next-state values are exported so the
// final iteration's result can be captured on the same edge it is computed.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic              run_i,
    input  logic              div_i,
    input  logic              word_i,
    input  logic [XLEN-1:0]   opa_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic              last_o,
    output logic [2*XLEN-1:0] prod_o,
    output logic [XLEN-1:0]   quo_o,
    output logic [XLEN-1:0]   rem_o
);

    localparam int CntW = $clog2(XLEN);

    logic [CntW-1:0]   cnt_q;
    logic              div_q;
    logic              word_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   shift_q;
    logic [2*XLEN-1:0] acc_q;

    logic [2*XLEN-1:0] mulAdd;
    logic [XLEN:0]     remShift;
    logic [XLEN:0]     remDiff;
    logic              divOk;
    logic [XLEN-1:0]   remNext;
    logic [XLEN-1:0]   quoNext;
    logic [CntW-1:0]   lastIdx;

    // Next accumulator for both modes: add-and-shift for multiply, trial subtract for divide
    always_comb begin
        mulAdd   = acc_q + (shift_q[0] ? mcand_q : '0);
        remShift = {acc_q[XLEN-1:0], shift_q[XLEN-1]};
        remDiff  = remShift - {1'b0, mcand_q[XLEN-1:0]};
        divOk    = ~remDiff[XLEN];
        remNext  = divOk ? remDiff[XLEN-1:0] : remShift[XLEN-1:0];
        quoNext  = {shift_q[XLEN-2:0], divOk};
        lastIdx  = word_q ? CntW'(WordBits - 1) : CntW'(XLEN - 1);
        last_o   = run_i && (cnt_q == lastIdx);
        prod_o   = mulAdd;
        quo_o    = quoNext;
        rem_o    = remNext;
    end

    // Operand load on start, one iteration per cycle while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= 1'b0;
            word_q  <= 1'b0;
            mcand_q <= '0;
            shift_q <= '0;
            acc_q   <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q  <= '0;
            div_q  <= div_i;
            word_q <= word_i;
            acc_q  <= '0;
            if (div_i) begin
                mcand_q <= {{XLEN{1'b0}}, opb_i};
                shift_q <= word_i ? (opa_i << WordBits) : opa_i;
            end else begin
                mcand_q <= {{XLEN{1'b0}}, opa_i};
                shift_q <= opb_i;
            end
        end else if (run_i) begin
            cnt_q <= last_o ? '0 : cnt_q + 1'b1;
            if (div_q) begin
                acc_q   <= {{XLEN{1'b0}}, remNext};
                shift_q <= quoNext;
            end else begin
                acc_q   <= mulAdd;
                mcand_q <= mcand_q << 1;
                shift_q <= shift_q >> 1;
            end
        end
    end

endmodule

// File: rtl/mdu.sv
// RV64M multiply/divide unit: handshake FSM, operand preprocessing,
// special-case divide shortcuts and sign correction around the iterative core.
module mdu
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    mdu_state_e      state_q;
    logic            outValid_q;
    logic [XLEN-1:0] result_q;
    logic [2:0]      funct3_q;
    logic            word_q;
    logic            sign1_q;
    logic            sign2_q;

    logic [2:0]        funct3;
    logic              isWord;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic              sign1;
    logic              sign2;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [XLEN-1:0]   minNeg;
    logic              divZero;
    logic              divOvf;
    logic              special;
    logic [XLEN-1:0]   specialRaw;
    logic [XLEN-1:0]   specialRes_d;
    logic              accept;

    logic              coreLast;
    logic [2*XLEN-1:0] coreProd;
    logic [XLEN-1:0]   coreQuo;
    logic [XLEN-1:0]   coreRem;
    logic [2*XLEN-1:0] prodSigned;
    logic [XLEN-1:0]   finalRaw;
    logic [XLEN-1:0]   finalRes_d;

    function automatic logic [XLEN-1:0] sextWord(input logic [XLEN-1:0] v);
        return {{(XLEN-WordBits){v[WordBits-1]}}, v[WordBits-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] zextWord(input logic [XLEN-1:0] v);
        return {{(XLEN-WordBits){1'b0}}, v[WordBits-1:0]};
    endfunction

    // Operand extension, magnitudes and the no-iteration divide shortcuts
    always_comb begin
        funct3 = in_op[2:0];
        isWord = in_op[MduWord];
        op1    = in_src1;
        op2    = in_src2;
        if (isWord) begin
            op1 = src1Signed(funct3) ? sextWord(in_src1) : zextWord(in_src1);
            op2 = src2Signed(funct3) ? sextWord(in_src2) : zextWord(in_src2);
        end
        sign1   = src1Signed(funct3) && op1[XLEN-1];
        sign2   = src2Signed(funct3) && op2[XLEN-1];
        mag1    = sign1 ? -op1 : op1;
        mag2    = sign2 ? -op2 : op2;
        minNeg  = isWord ? {{(XLEN-WordBits+1){1'b1}}, {(WordBits-1){1'b0}}}
                         : {1'b1, {(XLEN-1){1'b0}}};
        divZero = funct3[2] && (op2 == '0);
        divOvf  = ((funct3 == MduDiv) || (funct3 == MduRem)) && (op1 == minNeg) && (op2 == '1);
        special = divZero || divOvf;
        if (funct3[1]) begin
            specialRaw = divZero ? op1 : '0;
        end else begin
            specialRaw = divZero ? '1 : op1;
        end
        specialRes_d = word_qualify(isWord, specialRaw);
        accept       = (state_q == StIdle) && in_valid && !flush;
    end

    function automatic logic [XLEN-1:0] word_qualify(input logic w, input logic [XLEN-1:0] v);
        return w ? sextWord(v) : v;
    endfunction

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .start_i (accept && !special),
        .run_i   ((state_q == StBusy) && !flush),
        .div_i   (funct3[2]),
        .word_i  (isWord),
        .opa_i   (mag1),
        .opb_i   (mag2),
        .last_o  (coreLast),
        .prod_o  (coreProd),
        .quo_o   (coreQuo),
        .rem_o   (coreRem)
    );

    // Sign correction and result selection for the final iteration
    always_comb begin
        prodSigned = (sign1_q ^ sign2_q) ? -coreProd : coreProd;
        if (funct3_q[2]) begin
            if (funct3_q[1]) begin
                finalRaw = sign1_q ? -coreRem : coreRem;
            end else begin
                finalRaw = (sign1_q ^ sign2_q) ? -coreQuo : coreQuo;
            end
        end else if (funct3_q[1:0] == MduMul[1:0]) begin
            finalRaw = prodSigned[XLEN-1:0];
        end else begin
            finalRaw = prodSigned[2*XLEN-1:XLEN];
        end
        finalRes_d = word_qualify(word_q, finalRaw);
    end

    // Control FSM with registered result and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            outValid_q <= 1'b0;
            result_q   <= '0;
            funct3_q   <= '0;
            word_q     <= 1'b0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
        end else if (flush) begin
            state_q    <= StIdle;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        funct3_q <= funct3;
                        word_q   <= isWord;
                        sign1_q  <= sign1;
                        sign2_q  <= sign2;
                        if (special) begin
                            result_q   <= specialRes_d;
                            outValid_q <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (coreLast) begin
                        result_q   <= finalRes_d;
                        outValid_q <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = outValid_q;
    assign out_result = result_q;

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the RV64M extension. It sits in the execute stage beside the single-cycle ALU: the decoder routes `M`-class operations here instead of to the ALU. The unit computes one result bit per cycle behind a valid/ready request/response handshake, and returns a register-file-ready XLEN result.

## Interface
- `XLEN`, default 64: operand/result width. It equals the codebase `ImmWidth`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  pipeline kill; discards any in-flight or completed-but-unconsumed operation.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `in_op`  in  4  `{word, funct3}`:
  - funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
  - word=1 selects the W variant; valid only with funct3 0, 4, 5, 6, 7.
- `in_src1`  in  XLEN  rs1 operand.
- `in_src2`  in  XLEN  rs2 operand.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  XLEN  result; W ops return the sign-extended low 32 bits.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Reset values:** state IDLE, `in_ready`=1, `out_valid`=0, `out_result`=0, iteration counter 0.
- **IDLE → BUSY** on `in_valid && in_ready && !flush`. Operands, op and signs are latched at this transition.
  - Signed inputs are converted to magnitudes.
  - W ops first truncate operands to 32 bits, then sign- or zero-extend them per op.
- **Special divide cases: IDLE → DONE directly**, no iterations.
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / −1, at 32-bit width for W ops): quotient = dividend; remainder = 0.
- **BUSY iterations:** one per cycle. N = 32 for W ops, XLEN otherwise.
  - Multiply: shift-add, 2N-bit product accumulator.
  - Divide: restoring shift-subtract, N-bit quotient and remainder.
- **BUSY → DONE** when the counter reaches N−1. Sign correction is applied when loading the result register:
  - Product sign = s1 XOR s2.
  - Quotient sign = s1 XOR s2.
  - Remainder takes the sign of the dividend.
- **Result selection:**
  - MUL returns the low half of the product.
  - MULH, MULHSU and MULHU return the high half.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- **DONE:** `out_valid`=1 and `out_result` is held stable until `out_ready`. DONE → IDLE on `out_valid && out_ready`.
- **flush** in any state: next state is IDLE, `out_valid`=0. A killed result is never presented. `flush` has priority over `in_valid` and over `out_ready`.
- **Reset mid-operation:** immediate return to the reset values; no partial result is visible.

## Timing
- Request accepted at edge E0 (iterative case): BUSY from E0+1 through E0+N, and `out_valid` is high in the cycle after edge E0+N. Latency: 65 cycles for 64-bit ops, 33 for W ops.
- Special divide cases: `out_valid` high in the cycle after E0 (latency 1).
- Earliest next acceptance: the cycle after the output handshake. There is no overlap, so peak throughput is one op per N+2 cycles.
- `in_ready` is combinational from state only; it never depends on `in_valid`.
- `out_valid` and `out_result` are registered outputs.

## Structure
- Op encodings `MduMul`…`MduRemu`, the `MduWord` bit position and the state constants go in the shared `include/defines.v`, next to the `Alu*` codes.
- One sub-module, `mdu_iter_core`: the shift-add/shift-subtract datapath with its counter and start/done strobes. It is shared by multiply and divide via a mode input.
- `mdu` itself contains the FSM, the handshake, operand preprocessing and sign correction.

## Test plan
- MUL 7 × −3 → `out_result`=0xFFFF_FFFF_FFFF_FFEB, `out_valid` 65 cycles after acceptance.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × same → 0xFFFF_FFFF_FFFF_FFFE; MULH of the same operands → 0.
- DIV 5/0 → 0xFFFF_FFFF_FFFF_FFFF; REMU 5/0 → 5; DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000, REM → 0; each with latency 1.
- DIVW −7/2 → 0xFFFF_FFFF_FFFF_FFFD; REMW −7/2 → 0xFFFF_FFFF_FFFF_FFFF; latency 33; upper operand bits 0xDEAD_BEEF are ignored.
- Backpressure: `out_ready` held low 10 cycles after `out_valid` rises → result stable, `in_ready`=0 throughout; next request accepted the cycle after the handshake.
- `flush` at iteration 20 of a DIVU → no `out_valid` for that op, `in_ready`=1 next cycle. `rst_n` low mid-MUL → `out_valid`=0 and `out_result`=0 immediately.
